// File: rtl/vblank_update_sequencer.sv
// ---------------------------------------------------------------------------
// vblank_update_sequencer
//
// Per-frame scheduler for the game-logic update engines (ball physics, blob
// movement, score, ...). A rising edge on the VGA timing generator's vertical
// blank starts one sequence. Engines are started strictly one after another
// in index order, each with a start/done handshake. Clients that do not
// answer in time are abandoned and flagged. Work still running when active
// video resumes (vblank falls) is flagged as a frame overrun.
//
// Ports
//   pclk_i         pixel clock, all logic on the rising edge
//   rst_ni         asynchronous active-low reset
//   vblnk_i        vertical blank from the timing generator (pclk domain)
//   enable_i       1 = begin a sequence at each vblank rising edge
//   done_i         per-engine done, only looked at while that engine is awaited
//   err_clr_i      one-cycle pulse clearing overrun_o and timeout_err_o
//   start_o        one-hot, one-cycle start pulse to the engine being launched
//   active_idx_o   index of the engine currently started/awaited
//   seq_busy_o     1 while a sequence is in progress
//   frame_cnt_o    number of completed sequences (wraps)
//   overrun_o      sticky: vblank fell while a sequence was still running
//   timeout_err_o  sticky per-engine timeout flags
// ---------------------------------------------------------------------------
module vblank_update_sequencer #(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 16384,
  parameter int FCNT_W         = 16
) (
  input  logic                   pclk_i,
  input  logic                   rst_ni,
  input  logic                   vblnk_i,
  input  logic                   enable_i,
  input  logic [NUM_CLIENTS-1:0] done_i,
  input  logic                   err_clr_i,
  output logic [NUM_CLIENTS-1:0] start_o,
  output logic [2:0]             active_idx_o,
  output logic                   seq_busy_o,
  output logic [FCNT_W-1:0]      frame_cnt_o,
  output logic                   overrun_o,
  output logic [NUM_CLIENTS-1:0] timeout_err_o
);

  // Index width sized to the client count so done_i/start selects stay exact.
  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CLIENTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    NEXT
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   busy_q, busy_d;
  logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
  logic                   ovr_q, ovr_d;
  logic [NUM_CLIENTS-1:0] terr_q, terr_d;
  logic [NUM_CLIENTS-1:0] start_q, start_d;
  logic                   vblnk_q;

  logic                   rise, fall;
  logic [NUM_CLIENTS-1:0] terrSet;

  assign rise = vblnk_i & ~vblnk_q;
  assign fall = ~vblnk_i & vblnk_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    busy_d  = busy_q;
    fcnt_d  = fcnt_q;
    start_d = '0;
    terrSet = '0;

    case (state_q)
      // A rise while a sequence runs never reaches here, so missed frames
      // are simply dropped rather than queued.
      IDLE: begin
        if (rise && enable_i) begin
          state_d = START;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      // done is checked before the timeout so a reply on the last allowed
      // cycle still counts as success. The timer saturates instead of wrapping.
      WAIT: begin
        if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
        if (done_i[idx_q]) begin
          state_d = NEXT;
        end else if (timer_q == TIMER_LAST) begin
          terrSet[idx_q] = 1'b1;
          state_d        = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          fcnt_d  = fcnt_q + FCNT_W'(1);
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = START;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // start is registered together with the move into START, so it is high
    // exactly for the cycle the FSM spends in START.
    if (state_d == START) begin
      start_d[idx_d] = 1'b1;
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clr survives.
  assign ovr_d  = (fall & busy_q) | (ovr_q & ~err_clr_i);
  assign terr_d = terrSet | (terr_q & ~{NUM_CLIENTS{err_clr_i}});

  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
      ovr_q   <= 1'b0;
      terr_q  <= '0;
      start_q <= '0;
      vblnk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
      ovr_q   <= ovr_d;
      terr_q  <= terr_d;
      start_q <= start_d;
      vblnk_q <= vblnk_i;
    end
  end

  assign start_o       = start_q;
  assign active_idx_o  = 3'(idx_q);
  assign seq_busy_o    = busy_q;
  assign frame_cnt_o   = fcnt_q;
  assign overrun_o     = ovr_q;
  assign timeout_err_o = terr_q;

endmodule
